// File: rtl/cache_assoc_wb_if.sv
// CPU-side request port and main-memory port of cache_assoc_wb, bundled as one interface.
// The slave modport is the cache's view; the master modport is the surrounding system's view.
interface cache_assoc_wb_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 3
);
    logic              cpu_req;
    logic              cpu_wren;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ready;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              hit;
    logic              write_back;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_wren, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
        output cpu_ready, cpu_ack, cpu_rdata, hit, write_back,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_wren, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
        input  cpu_ready, cpu_ack, cpu_rdata, hit, write_back,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_assoc_wb.sv
// N-way set-associative write-back / write-allocate cache with true-LRU replacement.
// One word per block; victim write-back and fill run over a valid/ack memory handshake.
module cache_assoc_wb #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 3,
    parameter int INDEX_W = 2,
    parameter int WAYS    = 2
) (
    input logic            clock,
    input logic            reset,
    cache_assoc_wb_if.slave bus
);
    localparam int TAG_W = ADDR_W - INDEX_W;
    localparam int SETS  = 2 ** INDEX_W;
    localparam int AGE_W = $clog2(WAYS);
    localparam logic [AGE_W-1:0] OLDEST = AGE_W'(WAYS - 1);

    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, FILL, RESP} state_t;

    state_t state;

    logic              valid    [SETS][WAYS];
    logic              dirty    [SETS][WAYS];
    logic [AGE_W-1:0]  age      [SETS][WAYS];
    logic [TAG_W-1:0]  tag_mem  [SETS][WAYS];
    logic [DATA_W-1:0] data_mem [SETS][WAYS];

    logic              req_wren;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [AGE_W-1:0]  vic_way;

    logic              ready_q;
    logic              ack_q;
    logic [DATA_W-1:0] rdata_q;
    logic              hit_q;
    logic              wb_q;
    logic              mreq_q;
    logic              mwe_q;
    logic [ADDR_W-1:0] maddr_q;
    logic [DATA_W-1:0] mwdata_q;

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tg;

    assign idx = req_addr[INDEX_W-1:0];
    assign tg  = req_addr[ADDR_W-1:INDEX_W];

    logic             any_hit;
    logic [AGE_W-1:0] hit_way;
    logic             found_inv;
    logic [AGE_W-1:0] inv_way;
    logic [AGE_W-1:0] lru_way;
    logic [AGE_W-1:0] victim;
    logic             victim_dirty;

    always_comb begin
        any_hit   = 1'b0;
        hit_way   = '0;
        found_inv = 1'b0;
        inv_way   = '0;
        lru_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[idx][w] && tag_mem[idx][w] == tg) begin
                any_hit = 1'b1;
                hit_way = AGE_W'(w);
            end
            if (!valid[idx][w] && !found_inv) begin
                found_inv = 1'b1;
                inv_way   = AGE_W'(w);
            end
            if (age[idx][w] == OLDEST) begin
                lru_way = AGE_W'(w);
            end
        end
        victim       = found_inv ? inv_way : lru_way;
        victim_dirty = valid[idx][victim] && dirty[idx][victim];
    end

    // Line install/update and LRU touch requests for the current state.
    logic              line_we;
    logic [AGE_W-1:0]  line_way;
    logic [DATA_W-1:0] line_data;
    logic              touch_en;
    logic [AGE_W-1:0]  touch_way;
    logic [AGE_W-1:0]  touched_age [WAYS];

    always_comb begin
        line_we   = 1'b0;
        line_way  = vic_way;
        line_data = req_wdata;
        touch_en  = 1'b0;
        touch_way = vic_way;
        case (state)
            LOOKUP: begin
                if (any_hit) begin
                    touch_en  = 1'b1;
                    touch_way = hit_way;
                    line_way  = hit_way;
                    line_we   = req_wren;
                end else if (req_wren && !victim_dirty) begin
                    line_we   = 1'b1;
                    line_way  = victim;
                    touch_en  = 1'b1;
                    touch_way = victim;
                end
            end
            WRITEBACK: begin
                if (bus.mem_ack && req_wren) begin
                    line_we  = 1'b1;
                    touch_en = 1'b1;
                end
            end
            FILL: begin
                if (bus.mem_ack) begin
                    line_we   = 1'b1;
                    line_data = bus.mem_rdata;
                    touch_en  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            if (AGE_W'(w) == touch_way) begin
                touched_age[w] = '0;
            end else if (age[idx][w] < age[idx][touch_way]) begin
                touched_age[w] = age[idx][w] + AGE_W'(1);
            end else begin
                touched_age[w] = age[idx][w];
            end
        end
    end

    // Tag and data storage are not reset; valid bits gate their use.
    always_ff @(posedge clock) begin
        if (line_we) begin
            tag_mem[idx][line_way]  <= tg;
            data_mem[idx][line_way] <= line_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid[s][w] <= 1'b0;
                    dirty[s][w] <= 1'b0;
                    age[s][w]   <= AGE_W'(w);
                end
            end
            req_wren  <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            vic_way   <= '0;
            ready_q   <= 1'b1;
            ack_q     <= 1'b0;
            rdata_q   <= '0;
            hit_q     <= 1'b0;
            wb_q      <= 1'b0;
            mreq_q    <= 1'b0;
            mwe_q     <= 1'b0;
            maddr_q   <= '0;
            mwdata_q  <= '0;
        end else begin
            if (line_we) begin
                valid[idx][line_way] <= 1'b1;
                dirty[idx][line_way] <= req_wren;
            end
            if (touch_en) begin
                for (int w = 0; w < WAYS; w++) begin
                    age[idx][w] <= touched_age[w];
                end
            end
            case (state)
                IDLE: begin
                    if (bus.cpu_req) begin
                        req_wren  <= bus.cpu_wren;
                        req_addr  <= bus.cpu_addr;
                        req_wdata <= bus.cpu_wdata;
                        wb_q      <= 1'b0;
                        ready_q   <= 1'b0;
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    vic_way <= victim;
                    if (any_hit) begin
                        hit_q   <= 1'b1;
                        rdata_q <= req_wren ? req_wdata : data_mem[idx][hit_way];
                        state   <= RESP;
                    end else begin
                        hit_q <= 1'b0;
                        if (victim_dirty) begin
                            mreq_q   <= 1'b1;
                            mwe_q    <= 1'b1;
                            maddr_q  <= {tag_mem[idx][victim], idx};
                            mwdata_q <= data_mem[idx][victim];
                            state    <= WRITEBACK;
                        end else if (req_wren) begin
                            rdata_q <= req_wdata;
                            state   <= RESP;
                        end else begin
                            mreq_q  <= 1'b1;
                            mwe_q   <= 1'b0;
                            maddr_q <= req_addr;
                            state   <= FILL;
                        end
                    end
                end
                WRITEBACK: begin
                    if (bus.mem_ack) begin
                        wb_q  <= 1'b1;
                        mwe_q <= 1'b0;
                        if (req_wren) begin
                            mreq_q  <= 1'b0;
                            rdata_q <= req_wdata;
                            state   <= RESP;
                        end else begin
                            maddr_q <= req_addr;
                            state   <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (bus.mem_ack) begin
                        mreq_q  <= 1'b0;
                        rdata_q <= bus.mem_rdata;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    if (!ack_q) begin
                        ack_q <= 1'b1;
                    end else begin
                        ack_q   <= 1'b0;
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cpu_ready  = ready_q;
    assign bus.cpu_ack    = ack_q;
    assign bus.cpu_rdata  = rdata_q;
    assign bus.hit        = hit_q;
    assign bus.write_back = wb_q;
    assign bus.mem_req    = mreq_q;
    assign bus.mem_we     = mwe_q;
    assign bus.mem_addr   = maddr_q;
    assign bus.mem_wdata  = mwdata_q;
endmodule

// File: tb/tb_cache_assoc_wb.sv
// Bench for cache_assoc_wb: a 2-way and a 4-way instance share one stimulus driver, and a
// recency/shadow-memory model of cache behaviour predicts every response.
module tb_cache_assoc_wb;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    cache_assoc_wb_if #(.ADDR_W(5), .DATA_W(3)) b2 ();
    cache_assoc_wb_if #(.ADDR_W(5), .DATA_W(3)) b4 ();

    cache_assoc_wb #(.ADDR_W(5), .DATA_W(3), .INDEX_W(2), .WAYS(2)) dut2 (
        .clock(clock), .reset(reset), .bus(b2.slave));
    cache_assoc_wb #(.ADDR_W(5), .DATA_W(3), .INDEX_W(2), .WAYS(4)) dut4 (
        .clock(clock), .reset(reset), .bus(b4.slave));

    int         sel = 0;
    logic       req = 1'b0, wren = 1'b0, mack = 1'b0;
    logic [4:0] addr = '0;
    logic [2:0] wdata = '0, mrdata = '0;

    assign b2.cpu_req   = req & (sel == 0);
    assign b4.cpu_req   = req & (sel == 1);
    assign b2.cpu_wren  = wren;
    assign b4.cpu_wren  = wren;
    assign b2.cpu_addr  = addr;
    assign b4.cpu_addr  = addr;
    assign b2.cpu_wdata = wdata;
    assign b4.cpu_wdata = wdata;
    assign b2.mem_ack   = mack & (sel == 0);
    assign b4.mem_ack   = mack & (sel == 1);
    assign b2.mem_rdata = mrdata;
    assign b4.mem_rdata = mrdata;

    logic       o_ready, o_ack, o_hit, o_wb, o_mreq, o_mwe;
    logic [4:0] o_maddr;
    logic [2:0] o_rdata, o_mwdata;
    assign o_ready  = (sel == 0) ? b2.cpu_ready  : b4.cpu_ready;
    assign o_ack    = (sel == 0) ? b2.cpu_ack    : b4.cpu_ack;
    assign o_hit    = (sel == 0) ? b2.hit        : b4.hit;
    assign o_wb     = (sel == 0) ? b2.write_back : b4.write_back;
    assign o_mreq   = (sel == 0) ? b2.mem_req    : b4.mem_req;
    assign o_mwe    = (sel == 0) ? b2.mem_we     : b4.mem_we;
    assign o_maddr  = (sel == 0) ? b2.mem_addr   : b4.mem_addr;
    assign o_rdata  = (sel == 0) ? b2.cpu_rdata  : b4.cpu_rdata;
    assign o_mwdata = (sel == 0) ? b2.mem_wdata  : b4.mem_wdata;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req_v);
        end
    endtask

    // Reference model: main memory, the value the CPU should see per address, and which
    // blocks are resident/dirty with their last-use time.
    logic [2:0] mem_m    [2][32];
    logic [2:0] shadow   [2][32];
    bit         resident [2][32];
    bit         mdirty   [2][32];
    int         last_use [2][32];
    int         tick = 0;

    bit         e_hit, e_wb, e_fill;
    logic [4:0] e_wb_addr;
    logic [2:0] e_wb_data, e_rdata;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int a = 0; a < 32; a++) begin
                shadow[i][a]   = mem_m[i][a];
                resident[i][a] = 1'b0;
                mdirty[i][a]   = 1'b0;
                last_use[i][a] = 0;
            end
        end
    endtask

    task automatic model_access(input bit wr, input logic [4:0] a, input logic [2:0] d);
        int ways, cnt, v;
        logic [4:0] b;
        ways = (sel == 0) ? 2 : 4;
        e_hit = resident[sel][a];
        e_wb = 1'b0; e_fill = 1'b0; e_wb_addr = '0; e_wb_data = '0;
        if (!e_hit) begin
            cnt = 0; v = -1;
            for (int t = 0; t < 8; t++) begin
                b = {3'(t), a[1:0]};
                if (resident[sel][b]) begin
                    cnt++;
                    if (v < 0 || last_use[sel][b] < last_use[sel][v]) v = int'(b);
                end
            end
            if (cnt == ways) begin
                resident[sel][v] = 1'b0;
                if (mdirty[sel][v]) begin
                    e_wb = 1'b1;
                    e_wb_addr = 5'(v);
                    e_wb_data = shadow[sel][v];
                    mdirty[sel][v] = 1'b0;
                end
            end
            resident[sel][a] = 1'b1;
            mdirty[sel][a] = 1'b0;
            e_fill = !wr;
        end
        if (wr) begin
            shadow[sel][a] = d;
            mdirty[sel][a] = 1'b1;
        end
        tick++;
        last_use[sel][a] = tick;
        e_rdata = shadow[sel][a];
    endtask

    bit         g_ack, g_hit, g_wb;
    int         g_lat, n_wb, n_fill;
    logic [2:0] g_rdata, g_wb_data;
    logic [4:0] g_wb_addr, g_fill_addr;

    // Issue one request and act as main memory with the given wait states per transfer.
    task automatic do_access(input bit wr, input logic [4:0] a, input logic [2:0] d,
                             input int waits, input bit probe);
        int wcnt, cyc, guard;
        bit in_xfer, x_we;
        logic [4:0] x_addr;
        logic [2:0] x_wdata;
        g_ack = 0; g_hit = 0; g_wb = 0; g_lat = 0; n_wb = 0; n_fill = 0;
        g_rdata = '0; g_wb_data = '0; g_wb_addr = '0; g_fill_addr = '0;
        wcnt = 0; in_xfer = 0; x_we = 0; x_addr = '0; x_wdata = '0;
        guard = 0;
        @(negedge clock);
        while (!o_ready && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        check("ready_before_req", o_ready, 1);
        req = 1'b1; wren = wr; addr = a; wdata = d; mack = 1'b0;
        cyc = 0;
        while (!g_ack && cyc < 80) begin
            @(negedge clock);
            cyc++;
            mack  = 1'b0;
            wren  = 1'($urandom);
            addr  = 5'($urandom);
            wdata = 3'($urandom);
            req   = probe ? 1'($urandom) : 1'b0;
            if (o_ack) begin
                g_ack = 1; g_lat = cyc; g_rdata = o_rdata; g_hit = o_hit; g_wb = o_wb;
                req = 1'b0;
                check("ready_low_at_ack", o_ready, 0);
            end else if (o_mreq) begin
                if (!in_xfer) begin
                    in_xfer = 1; x_addr = o_maddr; x_we = o_mwe; x_wdata = o_mwdata;
                end else begin
                    check("mem_addr_stable", o_maddr, x_addr);
                    check("mem_we_stable", o_mwe, x_we);
                    if (x_we) check("mem_wdata_stable", o_mwdata, x_wdata);
                    check("ready_low_in_xfer", o_ready, 0);
                end
                if (wcnt == waits) begin
                    mack = 1'b1; wcnt = 0; in_xfer = 0;
                    if (o_mwe) begin
                        n_wb++; g_wb_addr = o_maddr; g_wb_data = o_mwdata;
                        mem_m[sel][o_maddr] = o_mwdata;
                    end else begin
                        n_fill++; g_fill_addr = o_maddr;
                        mrdata = mem_m[sel][o_maddr];
                    end
                end else begin
                    wcnt++;
                end
            end
        end
        req = 1'b0; mack = 1'b0;
        if (!g_ack) check("ack_timeout", 0, 1);
    endtask

    task automatic xact(input bit wr, input logic [4:0] a, input logic [2:0] d, input int waits,
                        input bit probe, input int req_hit, input int req_wb, input int req_rdata,
                        input string nm);
        model_access(wr, a, d);
        do_access(wr, a, d, waits, probe);
        check({nm, "_hit"}, g_hit, e_hit);
        check({nm, "_wbflag"}, g_wb, e_wb);
        check({nm, "_rdata"}, g_rdata, e_rdata);
        check({nm, "_nwb"}, n_wb, e_wb);
        check({nm, "_nfill"}, n_fill, e_fill);
        if (e_wb) begin
            check({nm, "_wb_addr"}, g_wb_addr, e_wb_addr);
            check({nm, "_wb_data"}, g_wb_data, e_wb_data);
        end
        if (e_fill) check({nm, "_fill_addr"}, g_fill_addr, a);
        check({nm, "_latency"}, g_lat, 3 + (int'(e_wb) + int'(e_fill)) * (waits + 1));
        if (req_hit >= 0)   check({nm, "_hit_const"}, g_hit, req_hit);
        if (req_wb >= 0)    check({nm, "_wb_const"}, g_wb, req_wb);
        if (req_rdata >= 0) check({nm, "_rdata_const"}, g_rdata, req_rdata);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; req = 1'b0; mack = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit         wr;
        logic [4:0] a;
        logic [2:0] d;
        int         waits;
        int         hit;
        int         wb;
        int         rdata;
    } vec_t;

    vec_t vt [9];

    initial begin
        int guard;
        logic [4:0] av;
        vt[0] = '{1'b0, 5'b00101, 3'b000, 0, 0, 0, 3'b110};
        vt[1] = '{1'b0, 5'b00101, 3'b000, 0, 1, 0, 3'b110};
        vt[2] = '{1'b1, 5'b00101, 3'b011, 1, 1, 0, 3'b011};
        vt[3] = '{1'b0, 5'b00101, 3'b000, 0, 1, 0, 3'b011};
        vt[4] = '{1'b0, 5'b01001, 3'b000, 1, 0, 0, 3'b010};
        vt[5] = '{1'b0, 5'b10001, 3'b000, 2, 0, 1, 3'b010};
        vt[6] = '{1'b1, 5'b11110, 3'b111, 0, 0, 0, 3'b111};
        vt[7] = '{1'b0, 5'b11110, 3'b000, 0, 1, 0, 3'b111};
        vt[8] = '{1'b0, 5'b00101, 3'b000, 1, 0, 0, 3'b011};

        for (int i = 0; i < 2; i++) begin
            for (int a = 0; a < 32; a++) begin
                av = 5'(a);
                mem_m[i][a] = av[2:0] ^ 3'b011;
            end
        end

        #1 reset = 1'b1;
        #1;
        check("rst_ready2", b2.cpu_ready, 1);
        check("rst_ack2", b2.cpu_ack, 0);
        check("rst_mreq2", b2.mem_req, 0);
        check("rst_hit2", b2.hit, 0);
        check("rst_wb2", b2.write_back, 0);
        check("rst_rdata2", b2.cpu_rdata, 0);
        check("rst_mwe2", b2.mem_we, 0);
        check("rst_maddr2", b2.mem_addr, 0);
        check("rst_ready4", b4.cpu_ready, 1);
        check("rst_mreq4", b4.mem_req, 0);
        check("rst_ack4", b4.cpu_ack, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();

        sel = 0;
        for (int i = 0; i < 9; i++) begin
            xact(vt[i].wr, vt[i].a, vt[i].d, vt[i].waits, 1'b0,
                 vt[i].hit, vt[i].wb, vt[i].rdata, $sformatf("vec%0d", i));
        end

        // Reset lands while a fill is waiting for mem_ack, between clock edges.
        @(negedge clock);
        req = 1'b1; wren = 1'b0; addr = 5'b01101; mack = 1'b0;
        @(negedge clock);
        req = 1'b0;
        guard = 0;
        while (!o_mreq && guard < 10) begin
            @(negedge clock);
            guard++;
        end
        check("midfill_mreq", o_mreq, 1);
        check("midfill_mwe", o_mwe, 0);
        #2 reset = 1'b1;
        #1;
        check("async_rst_mreq", o_mreq, 0);
        check("async_rst_ack", o_ack, 0);
        check("async_rst_ready", o_ready, 1);
        check("async_rst_wb", o_wb, 0);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        xact(1'b0, 5'b00101, 3'b000, 0, 1'b0, 0, 0, 3'b011, "post_rst");

        xact(1'b0, 5'b01110, 3'b000, 3, 1'b1, 0, 0, -1, "waitfill");
        xact(1'b0, 5'b01110, 3'b000, 0, 1'b1, 1, 0, -1, "waitfill_rehit");

        for (int n = 0; n < 150; n++) begin
            xact(1'($urandom), 5'($urandom), 3'($urandom), int'($urandom_range(0, 3)),
                 1'($urandom), -1, -1, -1, "rand2");
        end

        sel = 1;
        do_reset();
        xact(1'b0, 5'b00000, 3'b000, 0, 1'b0, 0, 0, -1, "w4_t0");
        xact(1'b0, 5'b00100, 3'b000, 0, 1'b0, 0, 0, -1, "w4_t1");
        xact(1'b0, 5'b01000, 3'b000, 1, 1'b0, 0, 0, -1, "w4_t2");
        xact(1'b0, 5'b01100, 3'b000, 0, 1'b0, 0, 0, -1, "w4_t3");
        xact(1'b0, 5'b10000, 3'b000, 0, 1'b0, 0, 0, -1, "w4_t4");
        xact(1'b0, 5'b00100, 3'b000, 0, 1'b0, 1, 0, -1, "w4_t1_again");
        xact(1'b0, 5'b00000, 3'b000, 0, 1'b0, 0, 0, -1, "w4_t0_evicted");

        for (int n = 0; n < 150; n++) begin
            xact(1'($urandom), 5'($urandom), 3'($urandom), int'($urandom_range(0, 3)),
                 1'($urandom), -1, -1, -1, "rand4");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
